// File: rtl/clk_div_pkg.sv
// Shared types and constants for the programmable clock divider controller.
// The optional period counter is enabled with the PERIOD_CNT_EN macro.
package clk_div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    PEND = 2'd2,
    STOP = 2'd3
  } state_e;

  localparam int     MIN_DIV     = 2;
  localparam state_e RST_STATE   = IDLE;
  localparam logic   RST_CLK_OUT = 1'b0;
  localparam logic   RST_TICK    = 1'b0;
  localparam logic   RST_CFG_ERR = 1'b0;

  // High phase covers the first floor(N/2) counts of the period.
  function automatic logic clk_level(input int unsigned k, input int unsigned n);
    return k < (n >> 1);
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Period counter with registered clk_out/tick compares and the end-of-period flag.
// The controller tells it whether to keep counting (go_i), whether this edge
// starts counting from IDLE (first_i), and which ratio the next period uses.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         go_i,
  input  logic         first_i,
  input  logic [W-1:0] div_i,
  input  logic [W-1:0] nxt_div_i,
  output logic         last_o,
  output logic         clk_out_o,
  output logic         tick_o
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         clk_q, clk_d;
  logic         tick_q, tick_d;

  // The final count of the current ratio marks the period boundary.
  assign last_o    = (cnt_q == (div_i - ONE));
  assign clk_out_o = clk_q;
  assign tick_o    = tick_q;

  // Next count and the output levels belonging to the count being entered.
  always_comb begin
    cnt_d  = '0;
    clk_d  = RST_CLK_OUT;
    tick_d = RST_TICK;
    if (go_i) begin
      if (first_i || last_o) begin
        cnt_d  = '0;
        clk_d  = clk_level(32'd0, 32'(nxt_div_i));
        tick_d = 1'b1;
      end else begin
        cnt_d  = cnt_q + ONE;
        clk_d  = clk_level(32'(cnt_q + ONE), 32'(div_i));
        tick_d = 1'b0;
      end
    end
  end

  // Counter and output registers; reset takes effect immediately.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      clk_q  <= RST_CLK_OUT;
      tick_q <= RST_TICK;
    end else begin
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      tick_q <= tick_d;
    end
  end

endmodule

// File: rtl/clk_div_sched.sv
// Run-time programmable integer clock divider controller.
// Ratio changes arrive on a valid/ready port and take effect only at a period
// boundary, so clk_out never shows a runt pulse. Define PERIOD_CNT_EN to add
// the 16-bit completed-period counter output.
module clk_div_sched
  import clk_div_pkg::*;
#(
  parameter int W       = 8,
  parameter int DEF_DIV = 4
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         en,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_err,
  output logic [W-1:0] cur_div,
  output logic         clk_out,
  output logic         tick,
  output logic         busy
`ifdef PERIOD_CNT_EN
  ,
  output logic [15:0]  period_cnt
`endif
);

  localparam logic [W-1:0] DEF_DIV_W = W'(DEF_DIV);
  localparam logic [W-1:0] MIN_DIV_W = W'(MIN_DIV);

  state_e       state_q, state_d;
  logic [W-1:0] cur_div_q, cur_div_d;
  logic [W-1:0] pend_div_q, pend_div_d;
  logic         pend_vld_q, pend_vld_d;
  logic         cfg_err_q, cfg_err_d;
  logic         accept, legal, last, go, first;

  assign cfg_ready = (state_q != PEND);
  assign busy      = (state_q != IDLE);
  assign cur_div   = cur_div_q;
  assign cfg_err   = cfg_err_q;
  assign accept    = cfg_valid & cfg_ready;
  assign legal     = (cfg_div >= MIN_DIV_W);
  assign go        = (state_d != IDLE);
  assign first     = (state_q == IDLE);

  // Next state, ratio bookkeeping and the illegal-ratio flag.
  always_comb begin
    state_d    = state_q;
    cur_div_d  = cur_div_q;
    pend_div_d = pend_div_q;
    pend_vld_d = pend_vld_q;
    cfg_err_d  = accept & ~legal;
    case (state_q)
      IDLE: begin
        if (accept && legal) cur_div_d = cfg_div;
        if (en) state_d = RUN;
      end
      default: begin
        if (last) begin
          // Boundary: a waiting ratio applies now; one accepted on this very
          // edge is newer and wins.
          if (pend_vld_q) cur_div_d = pend_div_q;
          if (accept && legal) cur_div_d = cfg_div;
          pend_vld_d = 1'b0;
          state_d    = en ? RUN : IDLE;
        end else begin
          if (accept && legal) begin
            pend_div_d = cfg_div;
            pend_vld_d = 1'b1;
          end
          if (!en)             state_d = STOP;
          else if (pend_vld_d) state_d = PEND;
          else                 state_d = RUN;
        end
      end
    endcase
  end

  // Controller state; reset discards any pending ratio.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q    <= RST_STATE;
      cur_div_q  <= DEF_DIV_W;
      pend_div_q <= DEF_DIV_W;
      pend_vld_q <= 1'b0;
      cfg_err_q  <= RST_CFG_ERR;
    end else begin
      state_q    <= state_d;
      cur_div_q  <= cur_div_d;
      pend_div_q <= pend_div_d;
      pend_vld_q <= pend_vld_d;
      cfg_err_q  <= cfg_err_d;
    end
  end

  clk_div_core #(
    .W(W)
  ) u_core (
    .clk_i     (clk_in),
    .rst_i     (rst),
    .go_i      (go),
    .first_i   (first),
    .div_i     (cur_div_q),
    .nxt_div_i (cur_div_d),
    .last_o    (last),
    .clk_out_o (clk_out),
    .tick_o    (tick)
  );

`ifdef PERIOD_CNT_EN
  logic [15:0] period_cnt_q;
  logic        seen_tick_q;

  assign period_cnt = period_cnt_q;

  // Count every tick except the very first since reset; wraps naturally.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      period_cnt_q <= 16'd0;
      seen_tick_q  <= 1'b0;
    end else if (tick) begin
      if (seen_tick_q) period_cnt_q <= period_cnt_q + 16'd1;
      seen_tick_q <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_clk_div_sched.sv
// Scoreboard bench for clk_div_sched: the driver pushes the hand-computed
// output set expected after each clock edge, the monitor pops and compares.
module tb_clk_div_sched;

  logic       clk_in = 1'b0;
  logic       rst, en, cfg_valid, cfg_ready, cfg_err, clk_out, tick, busy;
  logic [7:0] cfg_div, cur_div;
`ifdef PERIOD_CNT_EN
  logic [15:0] period_cnt;
`endif

  typedef struct {
    int         cyc;
    string      nm;
    logic       co, tk, bs, rdy, err;
    logic [7:0] dv;
  } exp_t;

  exp_t  sb[$];
  int    cyc_cnt = 0;
  int    checks  = 0;
  int    errors  = 0;
  logic  chk_now = 1'b0;
  string sc      = "reset";

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc_cnt <= cyc_cnt + 1;

  clk_div_sched #(.W(8), .DEF_DIV(4)) dut (
    .clk_in    (clk_in),
    .rst       (rst),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .cur_div   (cur_div),
    .clk_out   (clk_out),
    .tick      (tick),
    .busy      (busy)
`ifdef PERIOD_CNT_EN
    ,
    .period_cnt(period_cnt)
`endif
  );

  task automatic cmp1(input string nm, input string f, input logic a, input logic x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s %s: got %b expected %b (t=%0t)", nm, f, a, x, $time);
    end
  endtask

  task automatic cmp8(input string nm, input string f, input logic [7:0] a, input logic [7:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s %s: got %0d expected %0d (t=%0t)", nm, f, a, x, $time);
    end
  endtask

  // Monitor: compare every queued expectation that is due.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_in or posedge chk_now);
      while (sb.size() > 0 && sb[0].cyc <= cyc_cnt) begin
        e = sb.pop_front();
        if (e.cyc < cyc_cnt) begin
          checks++;
          errors++;
          $display("FAIL %s late: due cycle %0d seen at %0d", e.nm, e.cyc, cyc_cnt);
        end else begin
          cmp1(e.nm, "clk_out",   clk_out,   e.co);
          cmp1(e.nm, "tick",      tick,      e.tk);
          cmp1(e.nm, "busy",      busy,      e.bs);
          cmp1(e.nm, "cfg_ready", cfg_ready, e.rdy);
          cmp1(e.nm, "cfg_err",   cfg_err,   e.err);
          cmp8(e.nm, "cur_div",   cur_div,   e.dv);
        end
      end
    end
  end

  // Drive one cycle of inputs and expect the outputs after the coming edge.
  task automatic step(input logic e, input logic v, input logic [7:0] d,
                      input logic co, input logic tk, input logic bs,
                      input logic rdy, input logic err, input logic [7:0] dv);
    exp_t x;
    en = e; cfg_valid = v; cfg_div = d;
    x.cyc = cyc_cnt + 1; x.nm = sc;
    x.co = co; x.tk = tk; x.bs = bs; x.rdy = rdy; x.err = err; x.dv = dv;
    sb.push_back(x);
    @(posedge clk_in);
    #1;
  endtask

  // Several cycles with no offer; patterns are written in time order.
  task automatic run(input logic e, input string co, input string tk,
                     input logic bs, input logic [7:0] dv);
    for (int i = 0; i < co.len(); i++)
      step(e, 1'b0, 8'd0, co.getc(i) == "1", tk.getc(i) == "1", bs, 1'b1, 1'b0, dv);
  endtask

  // Check outputs right now, between clock edges.
  task automatic imm(input logic co, input logic tk, input logic bs,
                     input logic rdy, input logic err, input logic [7:0] dv);
    exp_t x;
    x.cyc = cyc_cnt; x.nm = sc;
    x.co = co; x.tk = tk; x.bs = bs; x.rdy = rdy; x.err = err; x.dv = dv;
    sb.push_back(x);
    chk_now = 1'b1;
    #1;
    chk_now = 1'b0;
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin : driver
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = 8'd0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in); #1;
    imm(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
    @(posedge clk_in); #1;
    rst = 1'b0;

    sc = "div4";
    run(1'b1, "11001100", "10001000", 1'b1, 8'd4);

    sc = "div5";
    step(1'b1, 1'b1, 8'd5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd5);
    run(1'b1, "100011000", "000010000", 1'b1, 8'd5);

    sc = "pend6";
    step(1'b1, 1'b1, 8'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd4);
    run(1'b1, "1", "0", 1'b1, 8'd4);
    step(1'b1, 1'b1, 8'd6, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4);
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4);
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd6);
    run(1'b1, "11000", "00000", 1'b1, 8'd6);

    sc = "illegal";
    run(1'b1, "1", "1", 1'b1, 8'd6);
    step(1'b1, 1'b1, 8'd1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 8'd6);
    run(1'b1, "10001", "00001", 1'b1, 8'd6);
    run(1'b1, "11000", "00000", 1'b1, 8'd6);
    step(1'b1, 1'b1, 8'd8, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd8);

    sc = "stop8";
    run(1'b0, "1110000", "0000000", 1'b1, 8'd8);
    run(1'b0, "00", "00", 1'b0, 8'd8);

    sc = "rst_pend";
    step(1'b0, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3);
    step(1'b1, 1'b0, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 8'd3);
    step(1'b1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd3);
    step(1'b1, 1'b1, 8'd7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd3);
    @(negedge clk_in); #1;
    en = 1'b0; cfg_valid = 1'b0; rst = 1'b1;
    #1;
    imm(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
    repeat (2) @(posedge clk_in);
    #1;
    rst = 1'b0;

    sc = "after_rst";
    run(1'b1, "11001", "10001", 1'b1, 8'd4);

    @(negedge clk_in); #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
